// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared helpers and encodings for the vector writeback path.
//   bitwidth(n)           : bits needed to represent the value n (min 1)
//   log2(n)               : ceil(log2(n)), used for FIFO pointer widths
//   beat_valid_offset(dw) : bit position of the valid flag in a result beat
//   beat_mask_offset(dw)  : bit position of the mask flag in a result beat
//   state_t               : writeback FSM encoding (IDLE, RUN, DRAIN)
// ---------------------------------------------------------------------------
package vec_pkg;

    function automatic int bitwidth(input int n);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(n)) w++;
        return w;
    endfunction

    function automatic int log2(input int n);
        int w;
        w = 0;
        while ((longint'(1) << w) < longint'(n)) w++;
        return w;
    endfunction

    // Beat layout: {valid, mask, data[dw-1:0]}
    function automatic int beat_valid_offset(input int dw);
        return dw + 1;
    endfunction

    function automatic int beat_mask_offset(input int dw);
        return dw;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vec_wb_fifo.sv
// ---------------------------------------------------------------------------
// vec_wb_fifo
// Small synchronous FIFO with a combinational head read so an entry pushed
// on one edge is visible at dout in the very next cycle.
// Ports:
//   clk, rst (async, active-low)
//   flush        : empties the FIFO (pointers and count cleared)
//   push, din    : write request / data; accepted when not full, or when
//                  a pop happens on the same edge
//   pop          : remove head; ignored when empty
//   dout         : current head entry
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module vec_wb_fifo
    import vec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/vec_wb_collect.sv
// ---------------------------------------------------------------------------
// vec_wb_collect
// Writeback collector for single-operand vector functional units. Numbers the
// incoming result beats 0..VLR-1, drops masked-off elements, buffers the rest
// (the units cannot stall) and drains them to the register-file write port.
// Ports:
//   clk, rst (async, active-low)
//   start            : begin a new operation (also aborts a running one)
//   VLR              : element count, sampled on start
//   fu_in            : {valid, mask, data} result beat
//   wr_en/idx/data   : register-file write request (FIFO head)
//   wr_ready         : write accepted this cycle
//   busy, done, err  : status; done is a one-cycle pulse, err is sticky
//   stall_cnt        : only with VEC_WB_STALL_CNT_EN; saturating count of
//                      cycles where a write was offered but not accepted
// Build option: define VEC_WB_STALL_CNT_EN to add the stall counter.
// ---------------------------------------------------------------------------
module vec_wb_collect
    import vec_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MVL        = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int VW         = bitwidth(MVL) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VW-1:0]         VLR,
    input  logic [DATA_WIDTH+1:0] fu_in,
    output logic                  wr_en,
    output logic [VW-1:0]         wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef VEC_WB_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int BEAT_VALID = beat_valid_offset(DATA_WIDTH);
    localparam int BEAT_MASK  = beat_mask_offset(DATA_WIDTH);

    state_t          state_reg;
    state_t          state_next;
    logic [VW-1:0]   vlr_reg;
    logic [VW-1:0]   cnt_reg;
    logic            done_reg;
    logic            err_reg;

    logic            beat_take;
    logic            in_range;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            overflow;
    logic            all_counted;
    logic            complete;
    logic [VW+DATA_WIDTH-1:0] fifo_dout;

    // Beats in the start cycle belong to no operation and are ignored.
    assign beat_take   = busy & fu_in[BEAT_VALID] & ~start;
    assign in_range    = (cnt_reg < vlr_reg);
    assign fifo_push   = beat_take & in_range & fu_in[BEAT_MASK];
    assign fifo_pop    = wr_en & wr_ready;
    assign overflow    = fifo_push & fifo_full & ~fifo_pop;
    assign all_counted = (cnt_reg == vlr_reg);
    assign complete    = busy & all_counted & fifo_empty;

    vec_wb_fifo #(
        .WIDTH (VW + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({cnt_reg, fu_in[DATA_WIDTH-1:0]}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_en              = ~fifo_empty;
    assign {wr_idx, wr_data}  = fifo_dout;
    assign busy               = (state_reg != IDLE);
    assign done               = done_reg;
    assign err                = err_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            RUN: begin
                if (complete)                       state_next = IDLE;
                else if (all_counted & ~fifo_empty) state_next = DRAIN;
            end
            DRAIN: begin
                if (complete) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A new operation always wins, even mid-operation.
        if (start) state_next = RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            vlr_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= complete & ~start;
            if (start) begin
                vlr_reg <= VLR;
                cnt_reg <= '0;
                err_reg <= 1'b0;
            end else begin
                if (beat_take & in_range) cnt_reg <= cnt_reg + VW'(1);
                // Excess beats and FIFO overflow both lose data.
                if ((beat_take & ~in_range) | overflow) err_reg <= 1'b1;
            end
        end
    end

`ifdef VEC_WB_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg <= '0;
        end else if (start) begin
            stall_reg <= '0;
        end else if (wr_en & ~wr_ready & (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_vec_wb_collect.sv
// ---------------------------------------------------------------------------
// tb_vec_wb_collect
// Directed scenarios followed by randomized operations. The driver updates a
// queue-based model of the writeback stream at each clock edge; a monitor on
// the falling edge pops expected writes and compares all status outputs.
// ---------------------------------------------------------------------------
module tb_vec_wb_collect;

    localparam int DW    = 32;
    localparam int MVL   = 32;
    localparam int DEPTH = 4;
    localparam int VW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [VW-1:0] VLR;
    logic [DW+1:0] fu_in;
    logic          wr_ready;
    logic          wr_en;
    logic [VW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;
`ifdef VEC_WB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    vec_wb_collect #(
        .DATA_WIDTH (DW),
        .MVL        (MVL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .VLR      (VLR),
        .fu_in    (fu_in),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
`ifdef VEC_WB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: the expected write stream plus operation bookkeeping.
    logic [VW+DW-1:0] exp_q[$];
    bit  m_busy = 0;
    bit  m_done = 0;
    bit  m_err  = 0;
    int  m_cnt  = 0;
    int  m_vlr  = 0;
    int  m_stall = 0;
    bit  pop_flag = 0;
    bit  stall_flag = 0;
    bit  mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the effect of the cycle that just ended (inputs still held).
    task automatic commit();
        if (start) begin
            m_busy  = 1;
            m_cnt   = 0;
            m_vlr   = int'(VLR);
            m_err   = 0;
            m_done  = 0;
            m_stall = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            if (stall_flag && m_stall < 65535) m_stall++;
            if (m_busy) begin
                // Buffer occupancy before the edge = what is left + what left now.
                if (m_cnt == m_vlr && (exp_q.size() + int'(pop_flag)) == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
                if (fu_in[DW+1]) begin
                    if (m_cnt < m_vlr) begin
                        if (fu_in[DW]) begin
                            if (exp_q.size() < DEPTH)
                                exp_q.push_back({VW'(m_cnt), fu_in[DW-1:0]});
                            else
                                m_err = 1;
                        end
                        m_cnt++;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
        pop_flag   = 0;
        stall_flag = 0;
    endtask

    task automatic drive(input bit st, input int vlr, input bit v, input bit m,
                         input logic [DW-1:0] d, input bit rdy);
        @(posedge clk);
        commit();
        #1;
        start    = st;
        VLR      = VW'(vlr);
        fu_in    = {v, m, d};
        wr_ready = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, rdy);
    endtask

    always @(negedge clk) begin
        logic [VW+DW-1:0] e;
        if (mon_en) begin
            check("wr_en", wr_en, exp_q.size() != 0);
            if (wr_en && wr_ready) begin
                pop_flag = 1;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("write idx=%0d data=%08h", wr_idx, wr_data);
                    check("wr_idx", wr_idx, e[VW+DW-1:DW]);
                    check("wr_data", wr_data, e[DW-1:0]);
                end
            end
            stall_flag = wr_en & ~wr_ready;
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("err", err, m_err);
`ifdef VEC_WB_STALL_CNT_EN
            check("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    initial begin
        int vlr;
        rst      = 1'b0;
        start    = 1'b0;
        VLR      = '0;
        fu_in    = '0;
        wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1;

        // Full mask, data 10..13
        drive(1, 4, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) drive(0, 4, 1, 1, DW'(10 + i), 1);
        idle(6, 1);

        // Alternating mask
        drive(1, 4, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) drive(0, 4, 1, (i % 2) == 0, DW'(32'hA + i), 1);
        idle(6, 1);

        // Overflow: writes blocked for five cycles
        drive(1, 6, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++) drive(0, 6, 1, 1, DW'(100 + i), i >= 5);
        idle(10, 1);

        // Empty vector
        drive(1, 0, 0, 0, '0, 1);
        idle(4, 1);

        // Restart mid-operation, then one beat too many
        drive(1, 8, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) drive(0, 8, 1, 1, DW'(200 + i), 1);
        drive(1, 8, 1, 1, DW'(32'hDEAD), 1);
        for (int i = 0; i < 9; i++) drive(0, 8, 1, 1, DW'(300 + i), 1);
        idle(6, 1);

        // Stalled writes
        drive(1, 2, 0, 0, '0, 0);
        drive(0, 2, 1, 1, DW'(55), 0);
        drive(0, 2, 1, 1, DW'(56), 0);
        idle(2, 0);
        idle(5, 1);

        // Randomized operations
        for (int op = 0; op < 40; op++) begin
            vlr = ($urandom_range(0, 7) == 0) ? MVL : int'($urandom_range(0, 12));
            drive(1, vlr, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 2) != 0);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 59) == 0) begin
                    vlr = int'($urandom_range(0, 12));
                    drive(1, vlr, $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                          $urandom_range(0, 2) != 0);
                end else begin
                    drive(0, vlr, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom,
                          $urandom_range(0, 2) != 0);
                end
                if (!m_busy) break;
            end
            // Beats while idle must be ignored
            for (int c = 0; c < 3; c++)
                drive(0, vlr, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1);
        end
        idle(8, 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
